ram_dump_reader: RTL and testbench

Read-side sweep engine for the dual-port RAM controller. On a start pulse it reads a contiguous address range (wrap-around allowed) through both RAM read ports, two words per issue cycle. It returns the data in address order on a valid/ready stream. It replaces ad-hoc testbench dump loops and is the standard way to unload RAM contents for checking or export.

---
 rtl/ram_dump_reader.sv | 123 ++++++++++++
 tb/tb_ram_dump_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_dump_reader.sv
// ram_dump_reader: sweeps an inclusive, wrapping address range over both RAM read ports
// and streams the words in address order on a valid/ready interface.
module ram_dump_reader #(
  parameter int WIDTH      = 32,
  parameter int AW         = 8,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [AW-1:0]    first_addr,
  input  logic [AW-1:0]    last_addr,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    addr0,
  output logic [AW-1:0]    addr1,
  output logic             wr,
  input  logic [WIDTH-1:0] r_out0,
  input  logic [WIDTH-1:0] r_out1,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 2;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [AW-1:0] cur_q, cur_d, a0_q, a1_q, span;
  logic [AW:0] rem_q, rem_d;
  logic [WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q, fl;
  logic iss, disc, out_v, out_d, stg_empty, push1, pop, last;

  assign span       = last_addr - first_addr;
  assign disc       = rem_q == (AW+1)'(1);
  // Words still in the read pipeline are counted against free space so the FIFO can never overflow.
  assign iss        = state_q == ISSUE && cnt_q + fl + CW'(2) <= CW'(FIFO_DEPTH);
  assign push1      = out_v & ~out_d;
  assign dout_valid = cnt_q != '0;
  assign dout       = dout_valid ? mem[rp_q] : '0;
  assign pop        = dout_valid & dout_ready;
  assign last       = state_q == DRAIN && stg_empty && cnt_q == CW'(1) && pop;
  assign done       = last;
  assign busy       = state_q != IDLE;
  assign wr         = 1'b0;
  assign addr0      = iss ? cur_q : a0_q;
  assign addr1      = iss ? cur_q + AW'(1) : a1_q;

  generate
    if (RD_LAT == 1) begin : g_comb
      assign out_v     = iss;
      assign out_d     = disc;
      assign fl        = '0;
      assign stg_empty = 1'b1;
    end else begin : g_pipe
      logic [RD_LAT-2:0] v_q, d_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          v_q <= '0;
          d_q <= '0;
        end else begin
          v_q <= (v_q << 1) | (RD_LAT-1)'(iss);
          d_q <= (d_q << 1) | (RD_LAT-1)'(iss & disc);
        end
      always_comb begin
        fl = '0;
        for (int k = 0; k < RD_LAT - 1; k++)
          fl = fl + (v_q[k] ? (d_q[k] ? CW'(1) : CW'(2)) : CW'(0));
      end
      assign out_v     = v_q[RD_LAT-2];
      assign out_d     = d_q[RD_LAT-2];
      assign stg_empty = v_q == '0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    if (state_q == IDLE && start) begin
      state_d = ISSUE;
      cur_d   = first_addr;
      rem_d   = {1'b0, span} + (AW+1)'(1);
    end
    if (iss) begin
      cur_d   = cur_q + AW'(2);
      rem_d   = rem_q - (disc ? (AW+1)'(1) : (AW+1)'(2));
      state_d = rem_d == '0 ? DRAIN : ISSUE;
    end
    if (last) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      a0_q    <= '0;
      a1_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      a0_q    <= addr0;
      a1_q    <= addr1;
      wp_q    <= wp_q + PW'(out_v) + PW'(push1);
      rp_q    <= rp_q + PW'(pop);
      cnt_q   <= cnt_q + CW'(out_v) + CW'(push1) - CW'(pop);
    end

  always_ff @(posedge clk) begin
    if (out_v) mem[wp_q] <= r_out0;
    if (push1) mem[wp_q + PW'(1)] <= r_out1;
  end

  always_ff @(posedge clk)
    if (rst_n) assert (cnt_q + CW'(out_v) + CW'(push1) <= CW'(FIFO_DEPTH));
endmodule

// File: tb/tb_ram_dump_reader.sv
// tb_ram_dump_reader: runs three readers (RD_LAT 1..3) in lockstep against one RAM image
// and compares each output stream with the address-ordered word list.
module tb_ram_dump_reader;
  logic clk = 0, rst_n = 0, start = 0, rdy = 1;
  logic [7:0] fa = 0, la = 0;
  logic [31:0] mem [256];
  logic [7:0] a0 [3], a1 [3];
  logic [31:0] r0 [3], r1 [3], dq [3];
  logic dv [3], dn [3], bz [3], wrx [3];
  logic prev_dn [3] = '{0, 0, 0};
  logic [31:0] got [3][2048];
  int ngot [3] = '{0, 0, 0}, ndone [3] = '{0, 0, 0}, dcyc [3], bafter [3];
  int base_got [3], base_done [3];
  int cyc = 0, pc = 0, mode = 0, errors = 0, checks = 0, s0 = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial forever begin
    @(posedge clk); #1;
    pc++;
    rdy = mode == 0 ? 1'b1 : mode == 1 ? (pc % 3 == 0) : 1'($urandom_range(0, 1));
  end

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L = g + 1;
    logic [7:0] h0 [3], h1 [3];
    always @(posedge clk) begin
      h0[0] <= a0[g]; h0[1] <= h0[0]; h0[2] <= h0[1];
      h1[0] <= a1[g]; h1[1] <= h1[0]; h1[2] <= h1[1];
    end
    assign r0[g] = L == 1 ? mem[a0[g]] : mem[h0[(L > 1) ? L - 2 : 0]];
    assign r1[g] = L == 1 ? mem[a1[g]] : mem[h1[(L > 1) ? L - 2 : 0]];
    ram_dump_reader #(.WIDTH(32), .AW(8), .RD_LAT(L), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .first_addr(fa), .last_addr(la),
      .busy(bz[g]), .done(dn[g]), .addr0(a0[g]), .addr1(a1[g]), .wr(wrx[g]),
      .r_out0(r0[g]), .r_out1(r1[g]), .dout(dq[g]), .dout_valid(dv[g]), .dout_ready(rdy));
  end

  always @(negedge clk)
    for (int g = 0; g < 3; g++) begin
      if (dv[g] && rdy) begin
        got[g][ngot[g] % 2048] = dq[g];
        ngot[g]++;
      end
      if (prev_dn[g]) bafter[g] = int'(bz[g]);
      if (dn[g]) begin
        ndone[g]++;
        dcyc[g] = cyc;
      end
      prev_dn[g] = dn[g];
    end

  task automatic snap;
    for (int g = 0; g < 3; g++) begin
      base_got[g] = ngot[g];
      base_done[g] = ndone[g];
    end
  endtask

  task automatic launch(input logic [7:0] f, input logic [7:0] l);
    @(posedge clk); #1;
    snap();
    fa = f; la = l; start = 1;
    @(posedge clk); #1;
    start = 0;
    s0 = cyc;
  endtask

  task automatic wait_all(input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (ndone[0] > base_done[0] && ndone[1] > base_done[1] && ndone[2] > base_done[2]) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({a0[g], a1[g]} !== 16'h0) begin errors++; $display("FAIL reset_addr inst%0d: got %h want 0", g, {a0[g], a1[g]}); end
      checks++;
      if ({dq[g], dv[g]} !== 33'h0) begin errors++; $display("FAIL reset_dout inst%0d: got %h want 0", g, {dq[g], dv[g]}); end
      checks++;
      if ({bz[g], dn[g], wrx[g]} !== 3'b000) begin errors++; $display("FAIL reset_ctrl inst%0d: got %b want 000", g, {bz[g], dn[g], wrx[g]}); end
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_sweep(input logic [7:0] f, input logic [7:0] l, input int m, input string nm);
    int n;
    bit ok;
    n = int'(8'(l - f)) + 1;
    mode = m;
    launch(f, l);
    wait_all(5000, ok);
    @(negedge clk); #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL %s timeout: got no done want done on all", nm); end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ndone[g] - base_done[g] !== 1) begin errors++; $display("FAIL %s done_count inst%0d: got %0d want 1", nm, g, ndone[g] - base_done[g]); end
      checks++;
      if (ngot[g] - base_got[g] !== n) begin errors++; $display("FAIL %s word_count inst%0d: got %0d want %0d", nm, g, ngot[g] - base_got[g], n); end
      for (int i = 0; i < n; i++) begin
        checks++;
        if (got[g][(base_got[g] + i) % 2048] !== mem[(int'(f) + i) % 256]) begin
          errors++;
          $display("FAIL %s data inst%0d word%0d: got %h want %h", nm, g, i, got[g][(base_got[g] + i) % 2048], mem[(int'(f) + i) % 256]);
        end
      end
      if (m == 0) begin
        checks++;
        if (dcyc[g] !== s0 - 1 + (g + 1) + n) begin errors++; $display("FAIL %s done_cycle inst%0d: got %0d want %0d", nm, g, dcyc[g] - s0, g + n); end
      end
      checks++;
      if (bafter[g] !== 0) begin errors++; $display("FAIL %s busy_after_done inst%0d: got %0d want 0", nm, g, bafter[g]); end
      checks++;
      if (wrx[g] !== 1'b0) begin errors++; $display("FAIL %s wr inst%0d: got %b want 0", nm, g, wrx[g]); end
    end
  endtask

  task automatic test_busy_ignore;
    bit ok;
    mode = 0;
    launch(8'h30, 8'h3F);
    repeat (4) @(posedge clk);
    #1;
    fa = 8'h80; la = 8'h81; start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_all(2000, ok);
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (!ok) begin errors++; $display("FAIL busy_ignore timeout: got no done want done on all"); end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ndone[g] - base_done[g] !== 1) begin errors++; $display("FAIL busy_ignore done_count inst%0d: got %0d want 1", g, ndone[g] - base_done[g]); end
      checks++;
      if (ngot[g] - base_got[g] !== 16) begin errors++; $display("FAIL busy_ignore word_count inst%0d: got %0d want 16", g, ngot[g] - base_got[g]); end
      checks++;
      if (bz[g] !== 1'b0) begin errors++; $display("FAIL busy_ignore busy inst%0d: got %b want 0", g, bz[g]); end
      for (int i = 0; i < 16; i++) begin
        checks++;
        if (got[g][(base_got[g] + i) % 2048] !== mem[8'h30 + i]) begin
          errors++;
          $display("FAIL busy_ignore data inst%0d word%0d: got %h want %h", g, i, got[g][(base_got[g] + i) % 2048], mem[8'h30 + i]);
        end
      end
      checks++;
      if (dcyc[g] !== s0 - 1 + (g + 1) + 16) begin errors++; $display("FAIL busy_ignore done_cycle inst%0d: got %0d want %0d", g, dcyc[g] - s0, g + 16); end
    end
  endtask

  task automatic test_midreset;
    int i;
    mode = 0;
    launch(8'h00, 8'h3F);
    for (i = 0; i < 200 && ngot[0] - base_got[0] < 5; i++) @(negedge clk);
    checks++;
    if (ngot[0] - base_got[0] < 5) begin errors++; $display("FAIL midreset progress: got %0d words want 5", ngot[0] - base_got[0]); end
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({a0[g], a1[g], dq[g], dv[g], bz[g], dn[g], wrx[g]} !== 52'h0) begin
        errors++;
        $display("FAIL midreset outputs inst%0d: got %h want 0", g, {a0[g], a1[g], dq[g], dv[g], bz[g], dn[g], wrx[g]});
      end
    end
    repeat (3) @(negedge clk);
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ndone[g] !== base_done[g]) begin errors++; $display("FAIL midreset no_done inst%0d: got %0d want %0d", g, ndone[g], base_done[g]); end
    end
    @(posedge clk); #1;
    rst_n = 1;
  endtask

  task automatic test_back_to_back;
    bit ok;
    int i;
    mode = 0;
    launch(8'h40, 8'h43);
    for (i = 0; i < 200 && ndone[2] == base_done[2]; i++) begin
      @(negedge clk); #1;
    end
    checks++;
    if (ndone[2] == base_done[2]) begin errors++; $display("FAIL back_to_back first_done: got none want 1"); end
    launch(8'h60, 8'h65);
    wait_all(500, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL back_to_back timeout: got no done want done on all"); end
    for (int g = 0; g < 3; g++) begin
      checks++;
      if (ngot[g] - base_got[g] !== 6) begin errors++; $display("FAIL back_to_back word_count inst%0d: got %0d want 6", g, ngot[g] - base_got[g]); end
      checks++;
      if (dcyc[g] !== s0 - 1 + (g + 1) + 6) begin errors++; $display("FAIL back_to_back done_cycle inst%0d: got %0d want %0d", g, dcyc[g] - s0, g + 6); end
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (got[g][(base_got[g] + k) % 2048] !== mem[8'h60 + k]) begin
          errors++;
          $display("FAIL back_to_back data inst%0d word%0d: got %h want %h", g, k, got[g][(base_got[g] + k) % 2048], mem[8'h60 + k]);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [7:0] f;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    for (int t = 0; t < 4; t++) begin
      f = 8'($urandom_range(0, 255));
      test_sweep(f, f + 8'($urandom_range(0, 40)), 2, "random");
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 + i;
    test_reset();
    test_sweep(8'h10, 8'h17, 0, "basic");
    test_sweep(8'h20, 8'h22, 0, "odd");
    test_sweep(8'h05, 8'h05, 0, "single");
    test_sweep(8'hFE, 8'h01, 0, "wrap");
    test_sweep(8'h00, 8'hFF, 1, "backpressure");
    test_sweep(8'h80, 8'h7F, 0, "full_range");
    test_busy_ignore();
    test_midreset();
    test_sweep(8'h50, 8'h57, 0, "post_reset");
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
